// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU with its own HI/LO registers.
// A started multiply runs for WIDTH shift-add iterations on operand magnitudes,
// then one fix-up cycle applies the sign and commits the 2*WIDTH-bit product.
module mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_multE,
    input  logic             signed_multE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiW,
    input  logic             mtloW,
    input  logic [WIDTH-1:0] wdataW,
    output logic             busy_multE,
    output logic             done_multE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } multState_t;

    multState_t stateQ, stateD;

    logic [2*WIDTH-1:0] mcandQ;
    logic [WIDTH-1:0]   mplierQ;
    logic [2*WIDTH-1:0] accQ;
    logic [CntW-1:0]    countQ;
    logic               negQ;
    logic [WIDTH-1:0]   hiQ;
    logic [WIDTH-1:0]   loQ;
    logic               doneQ;

    logic               startAccept;
    logic               lastIter;
    logic               negA;
    logic               negB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] accSum;
    logic [2*WIDTH-1:0] prodFixed;
    logic               regWriteOk;

    // A start is only honoured from IDLE; while busy it is ignored entirely.
    assign startAccept = start_multE & (stateQ == StIdle);
    assign lastIter    = (countQ == LastCnt);

    // MTHI/MTLO only land when the unit is idle and no product is being launched.
    assign regWriteOk  = (stateQ == StIdle) & ~start_multE;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
    always_comb begin
        negA = signed_multE & srcaE[WIDTH-1];
        negB = signed_multE & srcbE[WIDTH-1];
        magA = negA ? (WIDTH'(0) - srcaE) : srcaE;
        magB = negB ? (WIDTH'(0) - srcbE) : srcbE;
    end

    // One shift-add step and the final sign correction.
    always_comb begin
        addend    = mplierQ[0] ? mcandQ : '0;
        accSum    = accQ + addend;
        prodFixed = negQ ? ((2 * WIDTH)'(0) - accQ) : accQ;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next-state logic: IDLE -> RUN (WIDTH edges) -> FIX -> IDLE.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (start_multE) begin
                    stateD = StRun;
                end
            end
            StRun: begin
                if (lastIter) begin
                    stateD = StFix;
                end
            end
            StFix: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // FSM outputs: busy is decoded from state, the rest come straight from flops.
    always_comb begin
        busy_multE = (stateQ != StIdle);
        done_multE = doneQ;
        hi         = hiQ;
        lo         = loQ;
    end

    // Multiply datapath: operand capture on start, one iteration per RUN edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcandQ  <= '0;
            mplierQ <= '0;
            accQ    <= '0;
            countQ  <= '0;
            negQ    <= 1'b0;
        end else if (startAccept) begin
            mcandQ  <= {{WIDTH{1'b0}}, magA};
            mplierQ <= magB;
            accQ    <= '0;
            countQ  <= '0;
            negQ    <= signed_multE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        end else if (stateQ == StRun) begin
            accQ    <= accSum;
            mcandQ  <= {mcandQ[2*WIDTH-2:0], 1'b0};
            mplierQ <= {1'b0, mplierQ[WIDTH-1:1]};
            countQ  <= countQ + 1'b1;
        end
    end

    // HI/LO commit from FIX, otherwise idle-only writeback writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hiQ <= '0;
            loQ <= '0;
        end else if (stateQ == StFix) begin
            hiQ <= prodFixed[2*WIDTH-1:WIDTH];
            loQ <= prodFixed[WIDTH-1:0];
        end else if (regWriteOk) begin
            if (mthiW) begin
                hiQ <= wdataW;
            end
            if (mtloW) begin
                loQ <= wdataW;
            end
        end
    end

    // Single-cycle done pulse in the cycle after the product is committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            doneQ <= 1'b0;
        end else begin
            doneQ <= (stateQ == StFix);
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit (WIDTH = 32).
module tb_mult_unit;

    logic        clk;
    logic        reset;
    logic        start_multE;
    logic        signed_multE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        mthiW;
    logic        mtloW;
    logic [31:0] wdataW;
    logic        busy_multE;
    logic        done_multE;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    int cyc;

    mult_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_multE (start_multE),
        .signed_multE(signed_multE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .mthiW       (mthiW),
        .mtloW       (mtloW),
        .wdataW      (wdataW),
        .busy_multE  (busy_multE),
        .done_multE  (done_multE),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one multiply and watch 40 samples after the start edge.
    // At sample intrudeAt a second start and an MTLO are driven (both must be ignored).
    task automatic runMul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int intrudeAt, output int busyCyc, output int doneCnt);
        signed_multE = sgn;
        srcaE        = a;
        srcbE        = b;
        start_multE  = 1'b1;
        tick();
        start_multE  = 1'b0;
        srcaE        = 32'h0;
        srcbE        = 32'h0;
        busyCyc      = 0;
        doneCnt      = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_multE) busyCyc++;
            if (done_multE) doneCnt++;
            if (i == intrudeAt) begin
                start_multE = 1'b1;
                srcaE       = 32'h9;
                srcbE       = 32'h9;
                mtloW       = 1'b1;
                wdataW      = 32'hDEAD;
            end
            tick();
            start_multE = 1'b0;
            mtloW       = 1'b0;
            srcaE       = 32'h0;
            srcbE       = 32'h0;
        end
    endtask

    initial begin
        int busyCyc;
        int doneCnt;
        int firstDone;
        int secondDone;
        bit found;

        checks       = 0;
        failures     = 0;
        cyc          = 0;
        reset        = 1'b1;
        start_multE  = 1'b0;
        signed_multE = 1'b0;
        srcaE        = 32'h0;
        srcbE        = 32'h0;
        mthiW        = 1'b0;
        mtloW        = 1'b0;
        wdataW       = 32'h0;

        #2 reset = 1'b0;
        #10;
        check("rst_busy", {63'h0, busy_multE}, 64'h0);
        check("rst_done", {63'h0, done_multE}, 64'h0);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        reset = 1'b1;
        tick();

        // 1: MULTU max * max
        runMul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, busyCyc, doneCnt);
        check("t1_busy_cycles", 64'(busyCyc), 64'd33);
        check("t1_done_pulses", 64'(doneCnt), 64'd1);
        check("t1_hi", {32'h0, hi}, 64'hFFFFFFFE);
        check("t1_lo", {32'h0, lo}, 64'h00000001);

        // 2: signed corner cases
        runMul(1'b1, 32'h80000000, 32'h80000000, -1, busyCyc, doneCnt);
        check("t2a_hi", {32'h0, hi}, 64'h40000000);
        check("t2a_lo", {32'h0, lo}, 64'h00000000);
        runMul(1'b1, 32'hFFFFFFFF, 32'h00000001, -1, busyCyc, doneCnt);
        check("t2b_hi", {32'h0, hi}, 64'hFFFFFFFF);
        check("t2b_lo", {32'h0, lo}, 64'hFFFFFFFF);

        // 3: same operands, signed vs unsigned
        runMul(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, busyCyc, doneCnt);
        check("t3a_hi", {32'h0, hi}, 64'h00000000);
        check("t3a_lo", {32'h0, lo}, 64'h80000000);
        runMul(1'b0, 32'h80000000, 32'hFFFFFFFF, -1, busyCyc, doneCnt);
        check("t3b_hi", {32'h0, hi}, 64'h7FFFFFFF);
        check("t3b_lo", {32'h0, lo}, 64'h80000000);

        // 4: MTHI while idle, then MTLO + start while running are ignored
        mthiW  = 1'b1;
        wdataW = 32'h1234;
        tick();
        mthiW  = 1'b0;
        check("t4_mthi_hi", {32'h0, hi}, 64'h00001234);
        check("t4_mthi_lo_kept", {32'h0, lo}, 64'h80000000);
        runMul(1'b0, 32'd7, 32'd6, 5, busyCyc, doneCnt);
        check("t4_busy_cycles", 64'(busyCyc), 64'd33);
        check("t4_done_pulses", 64'(doneCnt), 64'd1);
        check("t4_hi", {32'h0, hi}, 64'h0);
        check("t4_lo", {32'h0, lo}, 64'h0000002A);

        // 5: asynchronous reset mid-RUN at count 10
        signed_multE = 1'b0;
        srcaE        = 32'hFFFF;
        srcbE        = 32'hFFFF;
        start_multE  = 1'b1;
        tick();
        start_multE  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t5_busy_before", {63'h0, busy_multE}, 64'h1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_busy", {63'h0, busy_multE}, 64'h0);
        check("t5_rst_done", {63'h0, done_multE}, 64'h0);
        check("t5_rst_hi", {32'h0, hi}, 64'h0);
        check("t5_rst_lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        runMul(1'b0, 32'd3, 32'd5, -1, busyCyc, doneCnt);
        check("t5_busy_cycles", 64'(busyCyc), 64'd33);
        check("t5_hi", {32'h0, hi}, 64'h0);
        check("t5_lo", {32'h0, lo}, 64'h0000000F);

        // 6: back-to-back start in the done cycle (with an MTHI that must be dropped)
        signed_multE = 1'b0;
        srcaE        = 32'd5;
        srcbE        = 32'd5;
        start_multE  = 1'b1;
        tick();
        start_multE  = 1'b0;
        found        = 1'b0;
        firstDone    = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done_multE) begin
                found     = 1'b1;
                firstDone = cyc;
            end else begin
                tick();
            end
        end
        check("t6_first_done_seen", {63'h0, found}, 64'h1);
        check("t6_lo1", {32'h0, lo}, 64'h00000019);
        srcaE       = 32'd2;
        srcbE       = 32'd2;
        start_multE = 1'b1;
        mthiW       = 1'b1;
        wdataW      = 32'hBEEF;
        tick();
        start_multE = 1'b0;
        mthiW       = 1'b0;
        srcaE       = 32'h0;
        srcbE       = 32'h0;
        check("t6_busy_after_restart", {63'h0, busy_multE}, 64'h1);
        check("t6_hi_during", {32'h0, hi}, 64'h0);
        found      = 1'b0;
        secondDone = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done_multE) begin
                found      = 1'b1;
                secondDone = cyc;
            end else begin
                tick();
            end
        end
        check("t6_second_done_seen", {63'h0, found}, 64'h1);
        check("t6_done_spacing", 64'(secondDone - firstDone), 64'd34);
        check("t6_hi2", {32'h0, hi}, 64'h0);
        check("t6_lo2", {32'h0, lo}, 64'h00000004);
        tick();
        check("t6_done_single", {63'h0, done_multE}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
